pad_io_serdes: RTL and testbench

- Parametrised core-side I/O bridge that sits between the pad ring and the compute core, one generation on from the fixed single-bit-output pad wrapper.
- Retimes a generalised set of pad input strobes and data into the core.
- Buffers wide core results in a small FIFO and serialises them onto LANES pad output pins, framed by out_valid.
- Lets the core run with a narrow pin budget at any result width.

---
 rtl/pad_io_serdes_if.sv | 21 ++
 rtl/pad_io_serdes.sv | 134 +++++++++++++
 tb/tb_pad_io_serdes.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pad_io_serdes_if.sv
// pad_io_serdes_if: pad inputs, retimed core inputs, result handshake and serial pad output of pad_io_serdes.
interface pad_io_serdes_if #(
  parameter int DATA_W = 12,
  parameter int NUM_VALID = 2,
  parameter int RES_W = 24,
  parameter int LANES = 1
);
  logic [NUM_VALID-1:0] pad_in_valid, core_in_valid;
  logic [DATA_W-1:0] pad_in_data, core_in_data;
  logic res_valid, res_ready, out_valid, ovf;
  logic [RES_W-1:0] res_data;
  logic [LANES-1:0] out_data;
  modport master (
    output pad_in_valid, pad_in_data, res_valid, res_data,
    input core_in_valid, core_in_data, res_ready, out_valid, out_data, ovf
  );
  modport slave (
    input pad_in_valid, pad_in_data, res_valid, res_data,
    output core_in_valid, core_in_data, res_ready, out_valid, out_data, ovf
  );
endinterface

// File: rtl/pad_io_serdes.sv
// pad_io_serdes: retimes pad inputs into the core and serialises FIFO-buffered results onto LANES pins.
// Optional OUT_PARITY_EN appends an even-parity beat to every frame.
module pad_io_serdes #(
  parameter int DATA_W = 12,
  parameter int NUM_VALID = 2,
  parameter int IN_STAGES = 1,
  parameter int RES_W = 24,
  parameter int LANES = 1,
  parameter int DEPTH = 4,
  parameter int GAP_CYCLES = 0
) (
  input logic clk,
  input logic rst_n,
  pad_io_serdes_if.slave io
);
  localparam int BEATS = RES_W / LANES;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam int GL = GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0;
  localparam int AW = $clog2(DEPTH);
  localparam int IW = NUM_VALID + DATA_W;
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd3;
`ifdef OUT_PARITY_EN
  localparam logic [1:0] PAR = 2'd2;
  logic par_q;
`endif
  logic [IW-1:0] pipe [IN_STAGES];
  logic [RES_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] occ;
  logic push, pop, empty, full, ovf_q;
  logic [1:0] st;
  logic [RES_W-1:0] sh;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic ov;
  logic [LANES-1:0] od;
  logic last, adv, fin, gap_done, try_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IN_STAGES; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {io.pad_in_valid, io.pad_in_data};
      for (int i = 1; i < IN_STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign {io.core_in_valid, io.core_in_data} = pipe[IN_STAGES-1];

  // Ready comes from registered occupancy only, so a same-cycle pop never frees a slot early.
  assign full = occ[AW];
  assign empty = occ == '0;
  assign push = io.res_valid && !full;
  assign io.res_ready = !full;
  assign io.ovf = ovf_q;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= io.res_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      occ <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
      ovf_q <= ovf_q || (io.res_valid && full);
    end
  end

  always_comb begin
    last = st == SHIFT && cnt == CW'(BEATS - 1);
    adv = st == SHIFT && !last;
`ifdef OUT_PARITY_EN
    fin = st == PAR;
`else
    fin = last;
`endif
    gap_done = st == GAP && gcnt == GW'(GL);
    // The final gap cycle may load the next frame directly, keeping the low stretch exactly GAP_CYCLES.
    try_load = st == IDLE || (fin && GAP_CYCLES == 0) || gap_done;
    pop = try_load && !empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      sh <= '0;
      cnt <= '0;
      gcnt <= '0;
      ov <= 1'b0;
      od <= '0;
`ifdef OUT_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      cnt <= adv ? cnt + 1'b1 : '0;
      if (pop) begin
        st <= SHIFT;
        ov <= 1'b1;
        od <= mem[rp][LANES-1:0];
        sh <= mem[rp] >> LANES;
`ifdef OUT_PARITY_EN
        par_q <= ^mem[rp];
`endif
      end else if (adv) begin
        od <= sh[LANES-1:0];
        sh <= sh >> LANES;
`ifdef OUT_PARITY_EN
      end else if (last) begin
        st <= PAR;
        od <= LANES'(par_q);
`endif
      end else if (fin && GAP_CYCLES > 0) begin
        st <= GAP;
        gcnt <= '0;
        ov <= 1'b0;
        od <= '0;
      end else if (st == GAP && !gap_done) begin
        gcnt <= gcnt + 1'b1;
      end else if (try_load) begin
        st <= IDLE;
        ov <= 1'b0;
        od <= '0;
      end
    end
  end
  assign io.out_valid = ov;
  assign io.out_data = od;
endmodule

// File: tb/tb_pad_io_serdes.sv
// tb_pad_io_serdes: directed plus random checks of two pad_io_serdes configurations against frame-level expectations.
module tb_pad_io_serdes;
  localparam int DW0 = 12, NV0 = 2, IS0 = 1, RW0 = 24, L0 = 1, G0 = 0, BT0 = RW0 / L0;
  localparam int DW1 = 8, NV1 = 3, IS1 = 2, RW1 = 16, L1 = 4, G1 = 2, BT1 = RW1 / L1;
`ifdef OUT_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  typedef struct {logic [63:0] val; logic [63:0] par; int gap;} frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, errors = 0;
  frame_t fq0[$], fq1[$];
  logic [63:0] exp0[$], exp1[$];
  logic [NV0+DW0-1:0] hist0[$];
  logic [NV1+DW1-1:0] hist1[$];
  int len0, len1, low0, low1, dirty0, dirty1, trunc0, trunc1;
  logic [63:0] acc0, acc1, par0, par1;

  always #5 clk = ~clk;

  pad_io_serdes_if #(.DATA_W(DW0), .NUM_VALID(NV0), .RES_W(RW0), .LANES(L0)) b0 ();
  pad_io_serdes_if #(.DATA_W(DW1), .NUM_VALID(NV1), .RES_W(RW1), .LANES(L1)) b1 ();

  pad_io_serdes #(.DATA_W(DW0), .NUM_VALID(NV0), .IN_STAGES(IS0), .RES_W(RW0), .LANES(L0),
    .DEPTH(4), .GAP_CYCLES(G0)) u0 (.clk(clk), .rst_n(rst_n), .io(b0.slave));
  pad_io_serdes #(.DATA_W(DW1), .NUM_VALID(NV1), .IN_STAGES(IS1), .RES_W(RW1), .LANES(L1),
    .DEPTH(4), .GAP_CYCLES(G1)) u1 (.clk(clk), .rst_n(rst_n), .io(b1.slave));

  // Frame collectors: rebuild each frame's value from its beats and note the idle run before it.
  always @(negedge clk) begin
    frame_t f;
    if (!rst_n) begin
      len0 = 0; acc0 = '0; par0 = '0; low0 = 1000;
    end else if (b0.out_valid) begin
      if (len0 < BT0) acc0 = acc0 | (64'(b0.out_data) << (len0 * L0));
      else par0 = 64'(b0.out_data);
      len0++;
      if (len0 == BT0 + PB) begin
        f.val = acc0; f.par = par0; f.gap = low0;
        fq0.push_back(f);
        len0 = 0; acc0 = '0; par0 = '0; low0 = 0;
      end
    end else begin
      if (len0 != 0) begin trunc0++; len0 = 0; acc0 = '0; end
      if (b0.out_data != '0) dirty0++;
      low0++;
    end
  end

  always @(negedge clk) begin
    frame_t f;
    if (!rst_n) begin
      len1 = 0; acc1 = '0; par1 = '0; low1 = 1000;
    end else if (b1.out_valid) begin
      if (len1 < BT1) acc1 = acc1 | (64'(b1.out_data) << (len1 * L1));
      else par1 = 64'(b1.out_data);
      len1++;
      if (len1 == BT1 + PB) begin
        f.val = acc1; f.par = par1; f.gap = low1;
        fq1.push_back(f);
        len1 = 0; acc1 = '0; par1 = '0; low1 = 0;
      end
    end else begin
      if (len1 != 0) begin trunc1++; len1 = 0; acc1 = '0; end
      if (b1.out_data != '0) dirty1++;
      low1++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check the retimed input path, then drive fresh random pad values.
  task automatic step();
    logic [31:0] r;
    @(posedge clk);
    #1;
    if (rst_n) begin
      chk("in_path0", 64'({b0.core_in_valid, b0.core_in_data}), 64'(hist0[hist0.size() - IS0]));
      chk("in_path1", 64'({b1.core_in_valid, b1.core_in_data}), 64'(hist1[hist1.size() - IS1]));
    end else begin
      hist0 = {};
      hist1 = {};
      repeat (IS0) hist0.push_back('0);
      repeat (IS1) hist1.push_back('0);
    end
    r = rst_n ? $urandom : 32'd0;
    {b0.pad_in_valid, b0.pad_in_data} = r[NV0+DW0-1:0];
    hist0.push_back(r[NV0+DW0-1:0]);
    r = rst_n ? $urandom : 32'd0;
    {b1.pad_in_valid, b1.pad_in_data} = r[NV1+DW1-1:0];
    hist1.push_back(r[NV1+DW1-1:0]);
    if (hist0.size() > 8) void'(hist0.pop_front());
    if (hist1.size() > 8) void'(hist1.pop_front());
  endtask

  task automatic push0(input logic [RW0-1:0] d, input bit rec);
    int n = 0;
    while (!b0.res_ready && n < 400) begin step(); n++; end
    chk("push0_wait", 64'(n < 400), 64'd1);
    b0.res_valid = 1'b1;
    b0.res_data = d;
    step();
    b0.res_valid = 1'b0;
    if (rec) exp0.push_back(64'(d));
  endtask

  task automatic push1(input logic [RW1-1:0] d, input bit rec);
    int n = 0;
    while (!b1.res_ready && n < 400) begin step(); n++; end
    chk("push1_wait", 64'(n < 400), 64'd1);
    b1.res_valid = 1'b1;
    b1.res_data = d;
    step();
    b1.res_valid = 1'b0;
    if (rec) exp1.push_back(64'(d));
  endtask

  task automatic drain(input int w);
    frame_t f;
    logic [63:0] v;
    int n = 0;
    while ((w == 0 ? fq0.size() < exp0.size() : fq1.size() < exp1.size()) && n < 3000) begin
      step();
      n++;
    end
    chk($sformatf("drain%0d_timeout", w), 64'(n < 3000), 64'd1);
    while (w == 0 ? (exp0.size() > 0 && fq0.size() > 0) : (exp1.size() > 0 && fq1.size() > 0)) begin
      if (w == 0) begin v = exp0.pop_front(); f = fq0.pop_front(); end
      else begin v = exp1.pop_front(); f = fq1.pop_front(); end
      chk($sformatf("frame%0d_val", w), f.val, v);
`ifdef OUT_PARITY_EN
      chk($sformatf("frame%0d_par", w), f.par, 64'(^v));
`endif
      if (w == 1) chk("frame1_gap", 64'(f.gap >= G1), 64'd1);
    end
    chk($sformatf("frame%0d_left", w),
      64'(w == 0 ? fq0.size() + exp0.size() : fq1.size() + exp1.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] v;
    int n;
    b0.res_valid = 1'b0; b0.res_data = '0;
    b1.res_valid = 1'b0; b1.res_data = '0;
    {b0.pad_in_valid, b0.pad_in_data} = '0;
    {b1.pad_in_valid, b1.pad_in_data} = '0;
    step();
    step();
    chk("rst_ov0", 64'(b0.out_valid), 64'd0);
    chk("rst_od0", 64'(b0.out_data), 64'd0);
    chk("rst_rdy0", 64'(b0.res_ready), 64'd1);
    chk("rst_ovf0", 64'(b0.ovf), 64'd0);
    chk("rst_core0", 64'({b0.core_in_valid, b0.core_in_data}), 64'd0);
    chk("rst_ov1", 64'(b1.out_valid), 64'd0);
    chk("rst_rdy1", 64'(b1.res_ready), 64'd1);
    chk("rst_core1", 64'({b1.core_in_valid, b1.core_in_data}), 64'd0);
    rst_n = 1'b1;

    // Single result: beat0 two cycles after acceptance, LSB first.
    v = 64'h00000B;
    push0(v[RW0-1:0], 1'b1);
    chk("lat_c1_ov", 64'(b0.out_valid), 64'd0);
    for (int k = 0; k < BT0; k++) begin
      step();
      chk($sformatf("beat%0d_ov", k), 64'(b0.out_valid), 64'd1);
      chk($sformatf("beat%0d_od", k), 64'(b0.out_data), (v >> k) & 64'h1);
    end
`ifdef OUT_PARITY_EN
    step();
    chk("par_ov", 64'(b0.out_valid), 64'd1);
    chk("par_od", 64'(b0.out_data), 64'(^v));
`endif
    step();
    chk("end_ov", 64'(b0.out_valid), 64'd0);
    chk("end_od", 64'(b0.out_data), 64'd0);
    drain(0);

    // Back-to-back frames with no idle cycle between them.
    push0(24'hFFFFFF, 1'b1);
    push0(24'h000001, 1'b1);
    n = 0;
    while (fq0.size() < 2 && n < 500) begin step(); n++; end
    chk("b2b_timeout", 64'(n < 500), 64'd1);
    if (fq0.size() > 1) chk("b2b_gap", 64'(fq0[1].gap), 64'd0);
    drain(0);

    // Fill the FIFO behind a running frame, overflow once, then watch ready return.
    push0(RW0'($urandom), 1'b1);
    step();
    chk("full_busy", 64'(b0.out_valid), 64'd1);
    repeat (4) push0(RW0'($urandom), 1'b1);
    chk("full_rdy", 64'(b0.res_ready), 64'd0);
    b0.res_valid = 1'b1;
    b0.res_data = RW0'($urandom);
    step();
    b0.res_valid = 1'b0;
    chk("ovf_set", 64'(b0.ovf), 64'd1);
    n = 5;
    while (!b0.res_ready && n < 200) begin step(); n++; end
    chk("rdy_rise", 64'(n), 64'(BT0 + PB));
    drain(0);
    chk("ovf_sticky", 64'(b0.ovf), 64'd1);

    // Four lanes with a two-cycle gap between queued frames.
    push1(16'hA5C3, 1'b1);
    push1(RW1'($urandom), 1'b1);
    n = 0;
    while (fq1.size() < 2 && n < 500) begin step(); n++; end
    chk("gap_timeout", 64'(n < 500), 64'd1);
    if (fq1.size() > 1) chk("gap_exact", 64'(fq1[1].gap), 64'(G1));
    drain(1);

    // Reset on beat 5 of a frame with another result still queued.
    push0(RW0'($urandom), 1'b0);
    push0(RW0'($urandom), 1'b0);
    repeat (5) step();
    chk("mid_ov", 64'(b0.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ov0", 64'(b0.out_valid), 64'd0);
    chk("mid_rst_od0", 64'(b0.out_data), 64'd0);
    chk("mid_rst_rdy0", 64'(b0.res_ready), 64'd1);
    chk("mid_rst_ovf0", 64'(b0.ovf), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (60) step();
    chk("no_resid0", 64'(fq0.size()), 64'd0);
    chk("no_resid1", 64'(fq1.size()), 64'd0);
    chk("post_rdy0", 64'(b0.res_ready), 64'd1);
    chk("post_ovf0", 64'(b0.ovf), 64'd0);

    // Random traffic to both instances.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) push0(RW0'($urandom), 1'b1);
      else push1(RW1'($urandom), 1'b1);
      repeat ($urandom_range(0, 12)) step();
    end
    drain(0);
    drain(1);
    chk("idle_data0", 64'(dirty0), 64'd0);
    chk("idle_data1", 64'(dirty1), 64'd0);
    chk("short_frame0", 64'(trunc0), 64'd0);
    chk("short_frame1", 64'(trunc1), 64'd0);
    chk("final_ovf0", 64'(b0.ovf), 64'd0);
    chk("final_ovf1", 64'(b1.ovf), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
